depth_stream_packer_fp16: RTL

//  Output stage directly downstream of dual_scale_wrapper_fp16: consumes its valid-only (no backpressure) z/c pixel

---
 rtl/depth_stream_packer_fp16_pkg.sv | 24 ++
 rtl/depth_stream_packer_fp16_fifo.sv | 87 ++++++++
 rtl/depth_stream_packer_fp16.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/depth_stream_packer_fp16_pkg.sv
// rtl/depth_stream_packer_fp16_pkg.sv - shared types for the depth stream packer
//
// Purpose: beat record carried through the packer FIFO and the packer FSM state encoding.
// Ports:   none (package).

package dfdd_pkg;

  localparam int FP16_WIDTH = 16;

  // One buffered pixel: frame/line markers travel with the data so the output side needs no position tracking.
  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [FP16_WIDTH-1:0] c;
    logic [FP16_WIDTH-1:0] z;
  } depth_beat_t;

  typedef enum logic [1:0] {
    WAIT_SOF,
    PASS,
    DISCARD
  } pack_state_t;

endpackage

// File: rtl/depth_stream_packer_fp16_fifo.sv
// rtl/depth_stream_packer_fp16_fifo.sv - synchronous FIFO with registered first-word-fall-through head
//
// Purpose: buffers beats between the valid-only pixel input and the backpressured output.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous reset, active-low
//   wr_en_i     write request (ignored while full)
//   wr_data_i   beat to write
//   full_o      level == DEPTH at the start of the cycle
//   rd_valid_o  registered head valid
//   rd_data_o   registered head data, zero when empty
//   rd_ready_i  consumer accepts the head this cycle
//   level_o     occupancy, including the entry shown on the head

module sync_fifo_fwft
  import dfdd_pkg::*;
#(
  parameter type T     = depth_beat_t,
  parameter int  DEPTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  T                       wr_data_i,
  output logic                   full_o,
  output logic                   rd_valid_o,
  output T                       rd_data_o,
  input  logic                   rd_ready_i,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          head_valid_q, head_valid_d;
  T              head_q, head_d;
  logic          wr;
  logic          pop;

  always_comb begin
    // Full is judged on the registered level, so a same-cycle pop never makes room for a write.
    full_o       = (level_q == LW'(DEPTH));
    wr           = wr_en_i && !full_o;
    pop          = head_valid_q && rd_ready_i;
    wr_ptr_d     = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d      = level_q + LW'(wr) - LW'(pop);
    head_valid_d = (level_d != '0);
    head_d       = '0;
    // The head register preloads the entry at the next read pointer. When that slot is being written this
    // cycle the storage does not hold it yet, so take it from the write port; it still appears one cycle later.
    if (head_valid_d) begin
      head_d = (wr && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign rd_valid_o = head_valid_q;
  assign rd_data_o  = head_q;
  assign level_o    = level_q;

endmodule

// File: rtl/depth_stream_packer_fp16.sv
// rtl/depth_stream_packer_fp16.sv - packs the z/c pixel stream into a framed, backpressured 32-bit stream
//
// Purpose: accepts a never-stalled pixel stream, buffers it and emits {c,z} beats with tuser = start of frame
//          and tlast = end of line. On overflow the rest of the frame is discarded and the output resyncs on
//          the next start of frame, so no torn frame leaves this block.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-low reset
//   z_i, c_i, col_i, row_i, valid_i      input pixel (no ready)
//   m_tdata_o, m_tvalid_o, m_tready_i    output stream, tdata = {c,z}
//   m_tlast_o, m_tuser_o                 end of line, start of frame
//   clear_i                              synchronous clear of counters and overflow_o
//   fifo_level_o                         FIFO occupancy
//   drop_count_o                         dropped pixels, saturating
//   frame_count_o                        start-of-frame pixels written, wrapping
//   overflow_o                           sticky drop indicator

module depth_stream_packer_fp16
  import dfdd_pkg::*;
#(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [15:0]                 z_i,
  input  logic [15:0]                 c_i,
  input  logic [15:0]                 col_i,
  input  logic [15:0]                 row_i,
  input  logic                        valid_i,
  output logic [31:0]                 m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  output logic                        m_tlast_o,
  output logic                        m_tuser_o,
  input  logic                        clear_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [15:0]                 drop_count_o,
  output logic [15:0]                 frame_count_o,
  output logic                        overflow_o
);

  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;

  // Reject configurations the datapath cannot represent.
  if (FP_WIDTH_REG != FP16_WIDTH || IMAGE_WIDTH < 1 || IMAGE_HEIGHT < 1 || FIFO_DEPTH < 4 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("depth_stream_packer_fp16: unsupported parameter set");
  end

  pack_state_t state_q, state_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        overflow_q, overflow_d;
  logic        sof;
  logic        eol;
  logic        full;
  logic        wr_en;
  logic        drop;
  depth_beat_t wr_beat;
  depth_beat_t head;
  logic        head_valid;

  assign sof     = valid_i && (col_i == 16'd0) && (row_i == 16'd0);
  assign eol     = (col_i == 16'(IMAGE_WIDTH - 1));
  assign wr_beat = '{sof: sof, eol: eol, c: c_i, z: z_i};

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    drop    = 1'b0;
    if (valid_i) begin
      case (state_q)
        PASS: begin
          if (!full) begin
            wr_en = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = DISCARD;
          end
        end
        WAIT_SOF, DISCARD: begin
          if (sof) begin
            if (!full) begin
              wr_en   = 1'b1;
              state_d = PASS;
            end else begin
              drop    = 1'b1;
              state_d = DISCARD;
            end
          end else if (state_q == DISCARD) begin
            // Pixels before the first SOF are not part of any frame and go uncounted.
            drop = 1'b1;
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_comb begin
    drop_count_d  = drop_count_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    if (clear_i) begin
      drop_count_d  = '0;
      frame_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end
      // Sticky: stays set whenever drop_count_o has moved since the last clear.
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (wr_en && sof) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= WAIT_SOF;
      drop_count_q  <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_count_q  <= drop_count_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .T     (depth_beat_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_beat),
    .full_o     (full),
    .rd_valid_o (head_valid),
    .rd_data_o  (head),
    .rd_ready_i (m_tready_i),
    .level_o    (fifo_level_o)
  );

  assign m_tdata_o     = {head.c, head.z};
  assign m_tvalid_o    = head_valid;
  assign m_tlast_o     = head.eol;
  assign m_tuser_o     = head.sof;
  assign drop_count_o  = drop_count_q;
  assign frame_count_o = frame_count_q;
  assign overflow_o    = overflow_q;

endmodule
